matched_filter_tdm: RTL and testbench

Time-multiplexed, parametrised complex matched filter that is the next generation of the team's fully parallel 250-tap design. It folds TAP_NUM complex taps onto LANES complex MAC lanes, so each output takes TAP_NUM/LANES MAC cycles. It adds a valid/ready input handshake, a runtime-writable coefficient store, an optional coefficient-conjugate mode, a programmable output shift with round-half-up, and saturation. It sits between the sample front end and the correlation-peak detector.

---
 rtl/matched_filter_tdm.sv | 175 +++++++++++++++++
 tb/tb_matched_filter_tdm.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matched_filter_tdm.sv
// Time-multiplexed complex matched filter: TAP_NUM taps folded onto LANES MAC lanes,
// with a valid/ready input, a writable coefficient store, conj mode, rounding and saturation.
module matched_filter_tdm #(
  parameter int TAP_NUM     = 256,
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int LANES       = 4,
  parameter int ACC_WIDTH   = 48,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  input  logic                         conj,
  input  logic                         coef_we,
  input  logic [$clog2(TAP_NUM)-1:0]   coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_real,
  input  logic signed [COEF_WIDTH-1:0] coef_imag,
  output logic                         coef_wr_err,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic                         out_sat
);

  localparam int PASSES = TAP_NUM / LANES;
  localparam int ADDR_W = $clog2(TAP_NUM);
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int PW     = DATA_WIDTH + COEF_WIDTH + 1;
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

  state_t                        state;
  logic [PASS_W-1:0]             pass_cnt;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic                          conj_q;
  logic signed [DATA_WIDTH-1:0]  x_re [TAP_NUM];
  logic signed [DATA_WIDTH-1:0]  x_im [TAP_NUM];
  logic signed [COEF_WIDTH-1:0]  c_re [TAP_NUM];
  logic signed [COEF_WIDTH-1:0]  c_im [TAP_NUM];
  logic signed [PW-1:0]          p_re [LANES];
  logic signed [PW-1:0]          p_im [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_re, acc_im;

  logic                          accept;
  logic [ADDR_W-1:0]             tap [LANES];
  logic signed [PW-1:0]          xr [LANES], xi [LANES], cr [LANES], ci [LANES];
  logic signed [PW-1:0]          lp_re [LANES], lp_im [LANES];
  logic signed [ACC_WIDTH-1:0]   lsum_re, lsum_im;
  logic signed [ACC_WIDTH:0]     half, sum_re, sum_im, r_re, r_im, q_re, q_im;
  logic                          sat_re, sat_im;

  assign accept = in_valid & in_ready;

  // Lane products for the current pass, plus the sum of the products registered last cycle.
  always_comb begin
    lsum_re = '0;
    lsum_im = '0;
    for (int l = 0; l < LANES; l++) begin
      tap[l]   = ADDR_W'(int'(pass_cnt) * LANES + l);
      xr[l]    = PW'(x_re[tap[l]]);
      xi[l]    = PW'(x_im[tap[l]]);
      cr[l]    = PW'(c_re[tap[l]]);
      ci[l]    = PW'(c_im[tap[l]]);
      lp_re[l] = conj_q ? (xr[l] * cr[l] + xi[l] * ci[l]) : (xr[l] * cr[l] - xi[l] * ci[l]);
      lp_im[l] = conj_q ? (xi[l] * cr[l] - xr[l] * ci[l]) : (xr[l] * ci[l] + xi[l] * cr[l]);
      lsum_re  = lsum_re + ACC_WIDTH'(p_re[l]);
      lsum_im  = lsum_im + ACC_WIDTH'(p_im[l]);
    end
  end

  // Round half toward +inf, then clamp into the output range.
  always_comb begin
    half   = (shift_q != '0) ? ((ACC_WIDTH + 1)'(1) <<< (shift_q - SHIFT_WIDTH'(1))) : '0;
    sum_re = (ACC_WIDTH + 1)'(acc_re) + half;
    sum_im = (ACC_WIDTH + 1)'(acc_im) + half;
    r_re   = sum_re >>> shift_q;
    r_im   = sum_im >>> shift_q;
    sat_re = (r_re > OUT_MAX) || (r_re < OUT_MIN);
    sat_im = (r_im > OUT_MAX) || (r_im < OUT_MIN);
    q_re   = (r_re > OUT_MAX) ? OUT_MAX : ((r_re < OUT_MIN) ? OUT_MIN : r_re);
    q_im   = (r_im > OUT_MAX) ? OUT_MAX : ((r_im < OUT_MIN) ? OUT_MIN : r_im);
  end

  // Coefficients survive reset, so they live outside the reset domain.
  always_ff @(posedge clk) begin
    if (coef_we && state == IDLE) begin
      c_re[coef_addr] <= coef_real;
      c_im[coef_addr] <= coef_imag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      out_sat     <= 1'b0;
      coef_wr_err <= 1'b0;
      pass_cnt    <= '0;
      shift_q     <= '0;
      conj_q      <= 1'b0;
      acc_re      <= '0;
      acc_im      <= '0;
      for (int l = 0; l < LANES; l++) begin
        p_re[l] <= '0;
        p_im[l] <= '0;
      end
      for (int k = 0; k < TAP_NUM; k++) begin
        x_re[k] <= '0;
        x_im[k] <= '0;
      end
    end else begin
      out_valid   <= 1'b0;
      coef_wr_err <= coef_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            for (int k = TAP_NUM - 1; k > 0; k--) begin
              x_re[k] <= x_re[k-1];
              x_im[k] <= x_im[k-1];
            end
            x_re[0]  <= in_real;
            x_im[0]  <= in_imag;
            acc_re   <= '0;
            acc_im   <= '0;
            for (int l = 0; l < LANES; l++) begin
              p_re[l] <= '0;
              p_im[l] <= '0;
            end
            pass_cnt <= '0;
            shift_q  <= shift;
            conj_q   <= conj;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          for (int l = 0; l < LANES; l++) begin
            p_re[l] <= lp_re[l];
            p_im[l] <= lp_im[l];
          end
          acc_re   <= acc_re + lsum_re;
          acc_im   <= acc_im + lsum_im;
          pass_cnt <= pass_cnt + PASS_W'(1);
          if (pass_cnt == PASS_W'(PASSES - 1)) state <= FLUSH;
        end
        FLUSH: begin
          acc_re <= acc_re + lsum_re;
          acc_im <= acc_im + lsum_im;
          state  <= OUT;
        end
        OUT: begin
          out_real  <= DATA_WIDTH'(q_re);
          out_imag  <= DATA_WIDTH'(q_im);
          out_sat   <= sat_re | sat_im;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matched_filter_tdm.sv
// Self-checking bench for matched_filter_tdm: a reference model pushes expected results
// into a scoreboard queue on every accept; each test task pops and compares DUT outputs.
module tb_matched_filter_tdm;

  localparam int TAP_NUM = 256;
  localparam int DW      = 16;
  localparam int CW      = 16;
  localparam int LANES   = 4;
  localparam int AW      = 48;
  localparam int SW      = 6;
  localparam int PASSES  = TAP_NUM / LANES;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real, in_imag;
  logic [SW-1:0]        shift;
  logic                 conj;
  logic                 coef_we;
  logic [7:0]           coef_addr;
  logic signed [CW-1:0] coef_real, coef_imag;
  logic                 coef_wr_err;
  logic                 out_valid;
  logic signed [DW-1:0] out_real, out_imag;
  logic                 out_sat;

  matched_filter_tdm #(
    .TAP_NUM(TAP_NUM), .DATA_WIDTH(DW), .COEF_WIDTH(CW),
    .LANES(LANES), .ACC_WIDTH(AW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .shift(shift), .conj(conj),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_real(coef_real), .coef_imag(coef_imag),
    .coef_wr_err(coef_wr_err), .out_valid(out_valid), .out_real(out_real),
    .out_imag(out_imag), .out_sat(out_sat)
  );

  typedef struct packed {int re; int im; logic sat;} res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   out_cyc_q[$];
  int   m_xr[TAP_NUM], m_xi[TAP_NUM], m_cr[TAP_NUM], m_ci[TAP_NUM];
  int   cyc;
  int   n_vec;
  int   n_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Output monitor: results are sampled on the falling edge, away from the DUT's updates.
  always @(negedge clk) begin
    res_t r;
    if (rst_n && out_valid) begin
      r.re  = int'(out_real);
      r.im  = int'(out_imag);
      r.sat = out_sat;
      obs_q.push_back(r);
      out_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_accept(input int xr, input int xi, input int sh, input int cj);
    longint sr, si;
    res_t   e;
    for (int k = TAP_NUM - 1; k > 0; k--) begin
      m_xr[k] = m_xr[k-1];
      m_xi[k] = m_xi[k-1];
    end
    m_xr[0] = xr;
    m_xi[0] = xi;
    sr = 0;
    si = 0;
    for (int k = 0; k < TAP_NUM; k++) begin
      if (cj == 0) begin
        sr += longint'(m_xr[k]) * m_cr[k] - longint'(m_xi[k]) * m_ci[k];
        si += longint'(m_xr[k]) * m_ci[k] + longint'(m_xi[k]) * m_cr[k];
      end else begin
        sr += longint'(m_xr[k]) * m_cr[k] + longint'(m_xi[k]) * m_ci[k];
        si += longint'(m_xi[k]) * m_cr[k] - longint'(m_xr[k]) * m_ci[k];
      end
    end
    if (sh > 0) begin
      sr += longint'(1) <<< (sh - 1);
      si += longint'(1) <<< (sh - 1);
    end
    sr = sr >>> sh;
    si = si >>> sh;
    e.sat = 1'b0;
    if (sr > 32767)  begin sr = 32767;  e.sat = 1'b1; end
    if (sr < -32768) begin sr = -32768; e.sat = 1'b1; end
    if (si > 32767)  begin si = 32767;  e.sat = 1'b1; end
    if (si < -32768) begin si = -32768; e.sat = 1'b1; end
    e.re = int'(sr);
    e.im = int'(si);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < TAP_NUM; k++) begin
      m_xr[k] = 0;
      m_xi[k] = 0;
    end
    exp_q.delete();
    obs_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic write_coef(input int addr, input int cr, input int ci);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 8'(addr);
    coef_real = 16'(cr);
    coef_imag = 16'(ci);
    @(negedge clk);
    coef_we   = 1'b0;
    m_cr[addr] = cr;
    m_ci[addr] = ci;
  endtask

  task automatic applyStimulus(input int xr, input int xi, input int sh, input int cj,
                               input bit we = 1'b0, input int wa = 0,
                               input int wcr = 0, input int wci = 0);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL send_timeout: in_ready=%0b, required 1", in_ready);
      return;
    end
    in_valid  = 1'b1;
    in_real   = 16'(xr);
    in_imag   = 16'(xi);
    shift     = 6'(sh);
    conj      = cj[0];
    coef_we   = we;
    coef_addr = 8'(wa);
    coef_real = 16'(wcr);
    coef_imag = 16'(wci);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (we) begin
      m_cr[wa] = wcr;
      m_ci[wa] = wci;
    end
    model_accept(xr, xi, sh, cj);
  endtask

  task automatic wait_outputs();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_real !== 16'sd0 || out_imag !== 16'sd0) begin
      n_miss++; $display("[TB] FAIL reset_out: got (%0d,%0d) want (0,0)", out_real, out_imag); end
    n_vec++; if (out_sat !== 1'b0 || coef_wr_err !== 1'b0) begin
      n_miss++; $display("[TB] FAIL reset_flags: got sat=%0b err=%0b want 0 0", out_sat, coef_wr_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_impulse(input int cj, input int n);
    res_t e, g;
    int   idx = 0;
    do_reset();
    applyStimulus(16384, 0, 14, cj);
    for (int i = 1; i < n; i++) applyStimulus(0, 0, 14, cj);
    wait_outputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) g = obs_q.pop_front(); else g = '{re: 999999, im: 999999, sat: 1'bx};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("[TB] FAIL impulse_conj%0d[%0d]: got (%0d,%0d,sat=%0b) want (%0d,%0d,sat=%0b)",
                 cj, idx, g.re, g.im, g.sat, e.re, e.im, e.sat);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid_mac();
    res_t e, g;
    applyStimulus(16384, 0, 14, 0);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_miss++; $display("[TB] FAIL midmac_ctrl: got valid=%0b ready=%0b want 0 1", out_valid, in_ready); end
    n_vec++; if (out_real !== 16'sd0 || out_imag !== 16'sd0 || out_sat !== 1'b0) begin
      n_miss++; $display("[TB] FAIL midmac_out: got (%0d,%0d,sat=%0b) want (0,0,0)", out_real, out_imag, out_sat); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < TAP_NUM; k++) begin m_xr[k] = 0; m_xi[k] = 0; end
    exp_q.delete();
    repeat (80) @(negedge clk);
    n_vec++; if (obs_q.size() != 0) begin
      n_miss++; $display("[TB] FAIL midmac_no_output: got %0d results want 0", obs_q.size()); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL midmac_ready: got %0b want 1", in_ready); end
    obs_q.delete();
    applyStimulus(16384, 0, 14, 0);
    for (int i = 1; i < 6; i++) applyStimulus(0, 0, 14, 0);
    wait_outputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) g = obs_q.pop_front(); else g = '{re: 999999, im: 999999, sat: 1'bx};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("[TB] FAIL midmac_impulse: got (%0d,%0d,sat=%0b) want (%0d,%0d,sat=%0b)",
                 g.re, g.im, g.sat, e.re, e.im, e.sat);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, g;
    int   acc_cyc[$];
    int   n_acc = 0;
    int   guard = 0;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_real  = 16'sd16384;
    in_imag  = 16'sd0;
    shift    = 6'd14;
    conj     = 1'b0;
    while (n_acc < 3 && guard < 400) begin
      if (in_ready) begin
        acc_cyc.push_back(cyc);
        model_accept(16384, 0, 14, 0);
        n_acc++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    wait_outputs();
    n_vec++; if (n_acc != 3 || out_cyc_q.size() != 3) begin
      n_miss++; $display("[TB] FAIL b2b_count: got %0d accepts %0d outputs want 3 3", n_acc, out_cyc_q.size()); end
    for (int i = 0; i < acc_cyc.size() && i < out_cyc_q.size(); i++) begin
      n_vec++;
      if (out_cyc_q[i] - acc_cyc[i] != PASSES + 3) begin
        n_miss++; $display("[TB] FAIL b2b_latency[%0d]: got %0d want %0d", i, out_cyc_q[i] - acc_cyc[i], PASSES + 3);
      end
      if (i > 0) begin
        n_vec++;
        if (acc_cyc[i] - acc_cyc[i-1] != PASSES + 3) begin
          n_miss++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], PASSES + 3);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) g = obs_q.pop_front(); else g = '{re: 999999, im: 999999, sat: 1'bx};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("[TB] FAIL b2b_result: got (%0d,%0d,sat=%0b) want (%0d,%0d,sat=%0b)",
                 g.re, g.im, g.sat, e.re, e.im, e.sat);
      end
    end
  endtask

  task automatic test_coef_error();
    res_t e, g;
    write_coef(5, 5, -5);
    n_vec++; if (coef_wr_err !== 1'b0) begin n_miss++; $display("[TB] FAIL idle_write_err: got %0b want 0", coef_wr_err); end
    applyStimulus(16384, 0, 14, 0);
    repeat (5) @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 8'd0;
    coef_real = 16'sd100;
    coef_imag = 16'sd100;
    @(negedge clk);
    coef_we = 1'b0;
    n_vec++; if (coef_wr_err !== 1'b1) begin n_miss++; $display("[TB] FAIL busy_write_err: got %0b want 1", coef_wr_err); end
    @(negedge clk);
    n_vec++; if (coef_wr_err !== 1'b0) begin n_miss++; $display("[TB] FAIL busy_write_pulse: got %0b want 0", coef_wr_err); end
    applyStimulus(16384, 0, 14, 0);
    wait_outputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) g = obs_q.pop_front(); else g = '{re: 999999, im: 999999, sat: 1'bx};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("[TB] FAIL coef_kept: got (%0d,%0d,sat=%0b) want (%0d,%0d,sat=%0b)",
                 g.re, g.im, g.sat, e.re, e.im, e.sat);
      end
    end
  endtask

  task automatic test_complex();
    res_t e, g;
    for (int k = 0; k < TAP_NUM; k++) write_coef(k, 0, 0);
    write_coef(0, 3, 4);
    do_reset();
    applyStimulus(1, 2, 0, 0);
    applyStimulus(1, 2, 0, 1);
    wait_outputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) g = obs_q.pop_front(); else g = '{re: 999999, im: 999999, sat: 1'bx};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("[TB] FAIL complex: got (%0d,%0d,sat=%0b) want (%0d,%0d,sat=%0b)",
                 g.re, g.im, g.sat, e.re, e.im, e.sat);
      end
    end
  endtask

  task automatic test_rounding();
    res_t e, g;
    applyStimulus(1, 0, 1, 0, 1'b1, 0, 3, 0);
    applyStimulus(-1, 0, 1, 0);
    wait_outputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) g = obs_q.pop_front(); else g = '{re: 999999, im: 999999, sat: 1'bx};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("[TB] FAIL rounding: got (%0d,%0d,sat=%0b) want (%0d,%0d,sat=%0b)",
                 g.re, g.im, g.sat, e.re, e.im, e.sat);
      end
    end
  endtask

  task automatic test_saturation(input int xr);
    res_t e, g;
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(xr, 0, 0, 0);
    wait_outputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) g = obs_q.pop_front(); else g = '{re: 999999, im: 999999, sat: 1'bx};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("[TB] FAIL saturation_%0d: got (%0d,%0d,sat=%0b) want (%0d,%0d,sat=%0b)",
                 xr, g.re, g.im, g.sat, e.re, e.im, e.sat);
      end
    end
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    shift     = '0;
    conj      = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_real = '0;
    coef_imag = '0;
    for (int k = 0; k < TAP_NUM; k++) begin
      m_xr[k] = 0; m_xi[k] = 0; m_cr[k] = 0; m_ci[k] = 0;
    end
    test_reset();
    for (int k = 0; k < TAP_NUM; k++) write_coef(k, k, -k);
    test_impulse(0, 40);
    test_impulse(1, 40);
    test_reset_mid_mac();
    test_back_to_back();
    test_coef_error();
    test_complex();
    test_rounding();
    for (int k = 0; k < TAP_NUM; k++) write_coef(k, 32767, 0);
    test_saturation(32767);
    test_saturation(-32768);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
